// File: rtl/stage_fetch.sv
// stage_fetch: instruction fetch stage with a debug-writable instruction memory
// and an IF/ID pipeline register.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   i_reset         asynchronous active-high reset (memory contents survive it)
//   is_enable       debug run/step enable; 0 freezes PC, IF/ID and state
//   is_pc_write     hazard-unit PC write enable (0 = load-use stall)
//   is_write_IF_ID  hazard-unit IF/ID write enable (0 = hold IF/ID)
//   is_branch_taken branch redirect request, target i_branch_addr
//   is_jump         jump redirect request, target i_jump_addr
//   is_mem_wr       debug instruction-memory write strobe
//   i_mem_wr_addr   word index for the debug write
//   i_mem_wr_data   instruction word for the debug write
//   o_pc            IF/ID PC+4 of the captured instruction
//   o_instruction   IF/ID captured instruction
//   os_stop_pipe    halt flag, sticky until reset
//   o_pc_current    live PC register
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_RUN  | fetching; PC advances, redirects and stalls honoured
// ST_HALT | halt word seen; PC frozen, IF/ID fed NOPs, left only via reset

module stage_fetch #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          is_enable,
    input  logic                          is_pc_write,
    input  logic                          is_write_IF_ID,
    input  logic                          is_branch_taken,
    input  logic [31:0]                   i_branch_addr,
    input  logic                          is_jump,
    input  logic [31:0]                   i_jump_addr,
    input  logic                          is_mem_wr,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_mem_wr_addr,
    input  logic [31:0]                   i_mem_wr_data,
    output logic [31:0]                   o_pc,
    output logic [31:0]                   o_instruction,
    output logic                          os_stop_pipe,
    output logic [31:0]                   o_pc_current
);

    localparam int          AW        = $clog2(IMEM_DEPTH);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] ifid_pc_q, ifid_pc_n;
    logic [31:0] ifid_instr_q, ifid_instr_n;

    logic [31:0] imem [IMEM_DEPTH];
    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_plus4;

    // Debug writes land at the edge and are independent of reset, enable and
    // halt, so the debugger can patch code while the core is frozen.
    always_ff @(posedge clk) begin
        if (is_mem_wr) begin
            imem[i_mem_wr_addr] <= i_mem_wr_data;
        end
    end

    // Upper PC bits are ignored, so fetch wraps modulo the memory size.
    assign fetch_idx  = pc_q[AW+1:2];
    assign fetch_word = imem[fetch_idx];
    assign pc_plus4   = pc_q + 32'd4;

    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        ifid_pc_n    = ifid_pc_q;
        ifid_instr_n = ifid_instr_q;

        if (is_enable) begin
            case (state_q)
                ST_RUN: begin
                    if (is_branch_taken || is_jump) begin
                        // Redirect flushes the wrong-path fetch, even when the
                        // hazard unit asked to hold IF/ID.
                        pc_n         = is_branch_taken ? i_branch_addr : i_jump_addr;
                        ifid_pc_n    = 32'd0;
                        ifid_instr_n = NOP_WORD;
                    end else if (!is_pc_write) begin
                        if (is_write_IF_ID) begin
                            ifid_pc_n    = pc_plus4;
                            ifid_instr_n = fetch_word;
                        end
                    end else if (fetch_word == HALT_WORD) begin
                        // Halt word is passed downstream once; PC stays on it.
                        state_n      = ST_HALT;
                        ifid_pc_n    = pc_plus4;
                        ifid_instr_n = fetch_word;
                    end else begin
                        pc_n = pc_plus4;
                        if (is_write_IF_ID) begin
                            ifid_pc_n    = pc_plus4;
                            ifid_instr_n = fetch_word;
                        end
                    end
                end
                ST_HALT: begin
                    ifid_pc_n    = 32'd0;
                    ifid_instr_n = NOP_WORD;
                end
                default: begin
                    state_n = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_RUN;
            pc_q         <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_WORD;
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            ifid_pc_q    <= ifid_pc_n;
            ifid_instr_q <= ifid_instr_n;
        end
    end

    assign o_pc          = ifid_pc_q;
    assign o_instruction = ifid_instr_q;
    assign o_pc_current  = pc_q;
    assign os_stop_pipe  = (state_q == ST_HALT);

endmodule

// File: tb/tb_stage_fetch.sv
module tb_stage_fetch;

   logic        clk;
   logic        i_reset;
   logic        is_enable;
   logic        is_pc_write;
   logic        is_write_IF_ID;
   logic        is_branch_taken;
   logic [31:0] i_branch_addr;
   logic        is_jump;
   logic [31:0] i_jump_addr;
   logic        is_mem_wr;
   logic [7:0]  i_mem_wr_addr;
   logic [31:0] i_mem_wr_data;
   logic [31:0] o_pc;
   logic [31:0] o_instruction;
   logic        os_stop_pipe;
   logic [31:0] o_pc_current;

   stage_fetch #(.IMEM_DEPTH(256)) dut (
      .clk            (clk),
      .i_reset        (i_reset),
      .is_enable      (is_enable),
      .is_pc_write    (is_pc_write),
      .is_write_IF_ID (is_write_IF_ID),
      .is_branch_taken(is_branch_taken),
      .i_branch_addr  (i_branch_addr),
      .is_jump        (is_jump),
      .i_jump_addr    (i_jump_addr),
      .is_mem_wr      (is_mem_wr),
      .i_mem_wr_addr  (i_mem_wr_addr),
      .i_mem_wr_data  (i_mem_wr_data),
      .o_pc           (o_pc),
      .o_instruction  (o_instruction),
      .os_stop_pipe   (os_stop_pipe),
      .o_pc_current   (o_pc_current)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] cur;
      logic        stop;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   stim_done = 1'b0;
   int   step_id = 0;

   localparam logic [31:0] W_A = 32'h1111_1111;
   localparam logic [31:0] W_B = 32'h2222_2222;
   localparam logic [31:0] W_C = 32'h3333_3333;
   localparam logic [31:0] HLT = 32'hFFFF_FFFF;

   // Push the expectation for the inputs currently applied, let one rising
   // edge consume them, and return just after the following falling edge.
   task automatic cyc(input logic [31:0] e_pc, input logic [31:0] e_ins,
                      input logic [31:0] e_cur, input logic e_stop);
      exp_t e;
      e.id = step_id; e.pc = e_pc; e.ins = e_ins; e.cur = e_cur; e.stop = e_stop;
      sb.push_back(e);
      step_id++;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      is_enable = 1'b1; is_pc_write = 1'b1; is_write_IF_ID = 1'b1;
      is_branch_taken = 1'b0; i_branch_addr = 32'd0;
      is_jump = 1'b0; i_jump_addr = 32'd0;
      is_mem_wr = 1'b0; i_mem_wr_addr = 8'd0; i_mem_wr_data = 32'd0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      is_mem_wr = 1'b1; i_mem_wr_addr = a; i_mem_wr_data = d;
   endtask

   // Monitor: compares registered outputs on each falling edge.
   initial begin : monitor
      exp_t e;
      bit   mis;
      while (1) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            mis = 1'b0;
            if (o_pc !== e.pc) mis = 1'b1;
            if (o_instruction !== e.ins) mis = 1'b1;
            if (o_pc_current !== e.cur) mis = 1'b1;
            if (os_stop_pipe !== e.stop) mis = 1'b1;
            if (mis) begin
               bad++;
               $display("FAIL step%0d: got pc=%h ins=%h cur=%h stop=%b, expected pc=%h ins=%h cur=%h stop=%b",
                        e.id, o_pc, o_instruction, o_pc_current, os_stop_pipe,
                        e.pc, e.ins, e.cur, e.stop);
            end
         end else if (stim_done) begin
            break;
         end
      end
      if (total == 0 || total != step_id) begin
         bad++;
         $display("FAIL: compared %0d of %0d steps", total, step_id);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      idle_inputs();
      i_reset = 1'b1;
      // Load memory while reset is held; writes must still land.
      wr(8'd0,   W_A);           cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd1,   W_B);           cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd2,   W_C);           cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd3,   32'h4444_4444); cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd16,  32'h5555_5555); cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd17,  32'h6666_6666); cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd18,  HLT);           cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd8,   32'h8888_8888); cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd10,  32'h1010_1010); cyc(32'd0, 32'd0, 32'd0, 1'b0);
      wr(8'd255, 32'h7777_7777); cyc(32'd0, 32'd0, 32'd0, 1'b0);

      // Sequential fetch after reset release
      idle_inputs(); i_reset = 1'b0;
      cyc(32'd4, W_A, 32'd4, 1'b0);
      cyc(32'd8, W_B, 32'd8, 1'b0);

      // Load-use stall at PC=8, two cycles
      is_pc_write = 1'b0; is_write_IF_ID = 1'b0;
      cyc(32'd8, W_B, 32'd8, 1'b0);
      cyc(32'd8, W_B, 32'd8, 1'b0);
      idle_inputs();
      cyc(32'd12, W_C, 32'd12, 1'b0);

      // Branch beats jump and overrides IF/ID hold
      is_branch_taken = 1'b1; i_branch_addr = 32'h40;
      is_jump = 1'b1; i_jump_addr = 32'h80; is_write_IF_ID = 1'b0;
      cyc(32'd0, 32'd0, 32'h40, 1'b0);
      idle_inputs();
      cyc(32'h44, 32'h5555_5555, 32'h44, 1'b0);
      cyc(32'h48, 32'h6666_6666, 32'h48, 1'b0);

      // Halt word at PC=0x48 discarded by simultaneous jump to 0x20
      is_jump = 1'b1; i_jump_addr = 32'h20;
      cyc(32'd0, 32'd0, 32'h20, 1'b0);
      idle_inputs();
      cyc(32'h24, 32'h8888_8888, 32'h24, 1'b0);

      // Disabled: patch word at PC index 9, everything else frozen
      is_enable = 1'b0; wr(8'd9, 32'h9999_9999);
      cyc(32'h24, 32'h8888_8888, 32'h24, 1'b0);
      idle_inputs();
      cyc(32'h28, 32'h9999_9999, 32'h28, 1'b0);

      // Write to the word being fetched: old contents captured
      wr(8'd10, 32'hAAAA_AAAA);
      cyc(32'h2C, 32'h1010_1010, 32'h2C, 1'b0);

      // Jump to 0xC while planting a halt word there
      idle_inputs(); is_jump = 1'b1; i_jump_addr = 32'hC; wr(8'd3, HLT);
      cyc(32'd0, 32'd0, 32'hC, 1'b0);
      idle_inputs();
      cyc(32'd16, HLT, 32'd12, 1'b1);
      // Halted: redirect ignored, NOPs drain, disable holds
      is_branch_taken = 1'b1; i_branch_addr = 32'h40;
      cyc(32'd0, 32'd0, 32'd12, 1'b1);
      idle_inputs(); is_enable = 1'b0;
      cyc(32'd0, 32'd0, 32'd12, 1'b1);
      idle_inputs();
      cyc(32'd0, 32'd0, 32'd12, 1'b1);

      // Reset clears halt; memory survives; first fetch is {4, mem[0]}
      i_reset = 1'b1;
      cyc(32'd0, 32'd0, 32'd0, 1'b0);
      i_reset = 1'b0;
      cyc(32'd4, W_A, 32'd4, 1'b0);

      // Upper PC bits ignored: 0x400 fetches word 0
      is_jump = 1'b1; i_jump_addr = 32'h400;
      cyc(32'd0, 32'd0, 32'h400, 1'b0);
      idle_inputs();
      cyc(32'h404, W_A, 32'h404, 1'b0);

      // PC+4 wraps modulo 2^32
      is_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFC;
      cyc(32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0);
      idle_inputs();
      cyc(32'd0, 32'h7777_7777, 32'd0, 1'b0);
      cyc(32'd4, W_A, 32'd4, 1'b0);

      // Stall with IF/ID write still enabled: PC holds, IF/ID recaptures
      is_pc_write = 1'b0;
      cyc(32'd8, W_B, 32'd4, 1'b0);
      idle_inputs();

      // Reset asserted in the middle of a stall
      is_pc_write = 1'b0; is_write_IF_ID = 1'b0; i_reset = 1'b1;
      cyc(32'd0, 32'd0, 32'd0, 1'b0);

      stim_done = 1'b1;
   end

endmodule

// File: doc/stage_fetch.md
STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: instruction memory depth in 32-bit words, power of two.
REQ-002 Port clk  in  1: single clock; all state updates on rising edge.
REQ-003 Port i_reset  in  1: reset, asynchronous and active-high.
REQ-004 Port is_enable  in  1: run/step enable from debug unit; 0 freezes all fetch state.
REQ-005 Port is_pc_write  in  1: hazard-unit PC write enable; 0 = load-use stall.
REQ-006 Port is_write_IF_ID  in  1: hazard-unit IF/ID write enable; 0 = hold IF/ID.
REQ-007 Port is_branch_taken  in  1: branch unit redirect request.
REQ-008 Port i_branch_addr  in  32: branch target byte address.
REQ-009 Port is_jump  in  1: jump redirect request.
REQ-010 Port i_jump_addr  in  32: jump target byte address.
REQ-011 Port is_mem_wr  in  1: debug instruction-memory write strobe.
REQ-012 Port i_mem_wr_addr  in  log2(IMEM_DEPTH): word index to write.
REQ-013 Port i_mem_wr_data  in  32: instruction word to write.
REQ-014 Port o_pc  out  32: IF/ID latched PC+4 of the captured instruction.
REQ-015 Port o_instruction  out  32: IF/ID latched instruction.
REQ-016 Port os_stop_pipe  out  1: registered halt flag, sticky until reset.
REQ-017 Port o_pc_current  out  32: live PC register, for debug readout.

Function
REQ-018 PC shall be a 32-bit byte address; memory index shall be PC[log2(IMEM_DEPTH)+1:2]; upper bits ignored, so fetch wraps modulo IMEM_DEPTH words.
REQ-019 Instruction read shall be combinational from PC; memory write shall occur at the clock edge, so a same-cycle fetch of the written word returns the old contents.
REQ-020 Memory writes shall be accepted regardless of is_enable, stall, halt or reset; memory contents shall not be cleared by reset.
REQ-021 State machine: RUN and HALTED; RUN->HALTED when an enabled, non-redirected, non-stalled fetch sees word 0xFFFFFFFF; HALTED->RUN only on reset.
REQ-022 Next-PC priority in RUN with is_enable=1: is_branch_taken (i_branch_addr) > is_jump (i_jump_addr) > is_pc_write=0 (hold) > halt word (hold) > PC+4, mod 2^32.
REQ-023 Redirect (branch or jump) shall load IF/ID instruction with 0x00000000 (NOP) and o_pc with 0, overriding is_write_IF_ID=0.
REQ-024 Without redirect, IF/ID shall capture {PC+4, fetched word} when is_write_IF_ID=1 and hold otherwise.
REQ-025 A halt word fetched while a redirect is active shall be discarded: no transition to HALTED.
REQ-026 On RUN->HALTED edge the halt word shall enter IF/ID and os_stop_pipe shall become 1 at that edge.
REQ-027 In HALTED: PC held, redirects ignored, IF/ID loads NOP each enabled cycle so downstream drains.
REQ-028 is_enable=0 shall hold PC, IF/ID, state and os_stop_pipe unchanged.

Reset
REQ-029 Asserting i_reset at any time shall immediately force PC=0, o_pc=0, o_instruction=0, os_stop_pipe=0, state=RUN, including mid-stall or in HALTED.
REQ-030 First enabled edge after reset release shall capture {0x4, mem[0]}.

Verification
REQ-031 Load mem[0..2]=A,B,C; run 3 cycles -> IF/ID sees (4,A),(8,B),(12,C); o_pc_current=12.
REQ-032 is_pc_write=0 and is_write_IF_ID=0 for 2 cycles at PC=8 -> PC stays 8, IF/ID holds (8,B); resumes with (12,C).
REQ-033 is_branch_taken=1, i_branch_addr=0x40 while is_write_IF_ID=0 -> IF/ID=(0,NOP) next edge, then (0x44,mem[16]); simultaneous is_jump ignored.
REQ-034 mem[3]=0xFFFFFFFF -> after fetch os_stop_pipe=1, PC=12, IF/ID=(16,0xFFFFFFFF), then (16... ) replaced by NOP on following edges; reset -> os_stop_pipe=0, PC=0.
REQ-035 Halt word fetched in same cycle as jump to 0x20 -> no halt, IF/ID=NOP, PC=0x20.
REQ-036 is_enable=0 with is_mem_wr writing mem[PC index] -> PC/IF/ID frozen, memory updated; after enable, new word captured.
